display_digit_scanner: RTL and testbench

Time-multiplexed scan controller for the multi-digit seven-segment display on the calculator.
- Holds a multi-digit hex value and presents one 4-bit digit per refresh slot on nibble_out, which feeds binary_to_7segment.binary_num.
- Drives the per-digit enable lines, delayed one cycle to line up with the decoder's one-cycle registered segment output.
- Double-buffers the displayed value so a digit scan never shows a mix of old and new digits (no tearing).
- Optionally blanks leading zeros.

---
 rtl/display_pkg.sv | 30 +++
 rtl/display_digit_scanner_refresh_divider.sv | 24 ++
 rtl/display_digit_scanner.sv | 94 +++++++++
 tb/tb_display_digit_scanner.sv | 139 +++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display helpers: digit width, enable polarity and leading-zero blanking.
// Used by the digit scanner and intended for reuse by other display blocks.
package display_pkg;

  localparam int DIGIT_W    = 4;
  // Upper bound on digits handled by the shared mask function.
  localparam int MAX_DIGITS = 16;

  // Map a logical "digit on" to the pin level for the given polarity.
  function automatic logic en_level(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

  // Bit i set when nibbles n-1 down to i are all zero (i >= 1); bit 0 never set.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [DIGIT_W*MAX_DIGITS-1:0] val,
    input int                            n
  );
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n) begin
        zero_run   = zero_run & (val[i*DIGIT_W +: DIGIT_W] == '0);
        lz_mask[i] = zero_run;
      end
    end
  endfunction

endpackage

// File: rtl/display_digit_scanner_refresh_divider.sv
// Free-running slot timer: a one-cycle tick every REFRESH_DIV clocks.
// The tick is combinational from the count so the consumer advances on the same edge the count wraps.
module refresh_divider #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int             CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_digit_scanner.sv
// Time-multiplexed seven-segment scan controller with a double-buffered value.
// digit_en is registered so it switches together with the decoder's registered segments.
module display_digit_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter bit EN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                  load,
  input  logic                  blank_leading_zeros,
  output logic [3:0]            nibble_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);
  import display_pkg::*;

  localparam int            IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int            VW       = DIGIT_W * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic                          tick, wrap;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [VW-1:0]                 disp_q, disp_d, shadow_q, shadow_d;
  logic                          pend_q, pend_d;
  logic [NUM_DIGITS-1:0]         en_q, en_d, blank;
  logic                          fd_q;
  logic [DIGIT_W*MAX_DIGITS-1:0] disp_ext;
  logic [MAX_DIGITS-1:0]         mask_full;

  refresh_divider #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap = tick && (idx_q == LAST_IDX);

  // Pending shadow commits at the wrap before a same-cycle load is captured.
  always_comb begin
    idx_d    = idx_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);
    if (wrap && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
    if (load) begin
      shadow_d = value_in;
      pend_d   = 1'b1;
    end
  end

  always_comb begin
    disp_ext         = '0;
    disp_ext[VW-1:0] = disp_q;
    mask_full        = lz_mask(disp_ext, NUM_DIGITS);
    nibble_out       = '0;
    blank            = '0;
    en_d             = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank[i] = mask_full[i] & blank_leading_zeros;
      if (idx_q == IW'(i)) nibble_out = disp_q[i*DIGIT_W +: DIGIT_W];
      en_d[i] = en_level((idx_q == IW'(i)) && !blank[i], EN_ACTIVE_LOW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      en_q     <= {NUM_DIGITS{EN_ACTIVE_LOW}};
      fd_q     <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      fd_q     <= wrap;
    end
  end

  assign digit_en   = en_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_display_digit_scanner.sv
// Scoreboard bench for display_digit_scanner (4 digits, 4-cycle slots, active-low enables).
module tb_display_digit_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_leading_zeros = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  typedef struct {
    logic [3:0] nib;
    logic [3:0] en;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t  q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  string tag = "reset";

  display_digit_scanner #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (4),
    .EN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .value_in            (value_in),
    .load                (load),
    .blank_leading_zeros (blank_leading_zeros),
    .nibble_out          (nibble_out),
    .digit_en            (digit_en),
    .frame_done          (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if ({nibble_out, digit_en, frame_done} === {e.nib, e.en, e.fd})
        n_pass++;
      else
        $display("FAIL %s @%0t: got nib=%h en=%b fd=%b, expected nib=%h en=%b fd=%b",
                 e.tag, $time, nibble_out, digit_en, frame_done, e.nib, e.en, e.fd);
    end
  end

  // Push the expectation for the cycle just started, then drive inputs for the next edge.
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] nib, input logic [3:0] en, input logic fd);
    exp_t e;
    @(posedge clk);
    #1;
    e.nib = nib; e.en = en; e.fd = fd; e.tag = tag;
    q.push_back(e);
    rst = r; load = ld; value_in = v;
  endtask

  // One 4-cycle slot: first cycle still shows the previous enable (pen).
  task automatic slot(input logic [3:0] nib, input logic [3:0] pen, input logic [3:0] en,
                      input logic fd, input int ldc, input logic [15:0] lv);
    for (int c = 0; c < 4; c++)
      step(1'b0, c == ldc, lv, nib, (c == 0) ? pen : en, (c == 0) ? fd : 1'b0);
  endtask

  initial begin
    tag = "reset";
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'hF, 1'b0);

    tag = "first_frame_zero";
    slot(4'h0, 4'hF, 4'hE, 1'b0, 1, 16'h12AB);
    slot(4'h0, 4'hE, 4'hD, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hD, 4'hB, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hB, 4'h7, 1'b0, -1, 16'h0);

    tag = "show_12AB";
    slot(4'hB, 4'h7, 4'hE, 1'b1, -1, 16'h0);
    slot(4'hA, 4'hE, 4'hD, 1'b0, -1, 16'h0);
    tag = "no_tear";
    slot(4'h2, 4'hD, 4'hB, 1'b0, 1, 16'h3456);
    slot(4'h1, 4'hB, 4'h7, 1'b0, -1, 16'h0);

    tag = "show_3456";
    slot(4'h6, 4'h7, 4'hE, 1'b1, -1, 16'h0);
    tag = "back_to_back_load";
    step(1'b0, 1'b1, 16'h1111, 4'h5, 4'hE, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 4'h5, 4'hD, 1'b0);
    step(1'b0, 1'b0, 16'h0,    4'h5, 4'hD, 1'b0);
    step(1'b0, 1'b0, 16'h0,    4'h5, 4'hD, 1'b0);
    slot(4'h4, 4'hD, 4'hB, 1'b0, -1, 16'h0);
    tag = "load_on_boundary";
    slot(4'h3, 4'hB, 4'h7, 1'b0, 3, 16'h0050);

    tag = "show_2222";
    blank_leading_zeros = 1'b1;
    slot(4'h2, 4'h7, 4'hE, 1'b1, -1, 16'h0);
    slot(4'h2, 4'hE, 4'hD, 1'b0, -1, 16'h0);
    slot(4'h2, 4'hD, 4'hB, 1'b0, -1, 16'h0);
    slot(4'h2, 4'hB, 4'h7, 1'b0, -1, 16'h0);

    tag = "blank_0050";
    slot(4'h0, 4'h7, 4'hE, 1'b1, 1, 16'h0000);
    slot(4'h5, 4'hE, 4'hD, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hD, 4'hF, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hF, 4'hF, 1'b0, -1, 16'h0);

    tag = "blank_0000";
    slot(4'h0, 4'hF, 4'hE, 1'b1, 1, 16'hAAAA);
    slot(4'h0, 4'hE, 4'hF, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hF, 4'hF, 1'b0, -1, 16'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 4'hF, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'hF, 1'b0);

    tag = "after_mid_reset";
    slot(4'h0, 4'hF, 4'hE, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hE, 4'hF, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hF, 4'hF, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hF, 4'hF, 1'b0, -1, 16'h0);
    slot(4'h0, 4'hF, 4'hE, 1'b1, -1, 16'h0);
    slot(4'h0, 4'hE, 4'hF, 1'b0, -1, 16'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
